// File: rtl/vector_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_sequencer_if
// Brief    : Bus bundle between a test controller and vector_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface vector_sequencer_if #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 7
);
  logic              wr_en;
  logic [6:0]        wr_addr;
  logic [IN_W:0]     wr_data;
  logic              start;
  logic [7:0]        len;
  logic              abort;
  logic              dut_rst;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              busy;
  logic              done;
  logic [15:0]       signature;
  logic [7:0]        vec_idx;

  modport master (
    output wr_en, wr_addr, wr_data, start, len, abort, dut_out,
    input  dut_rst, dut_in, busy, done, signature, vec_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, len, abort, dut_out,
    output dut_rst, dut_in, busy, done, signature, vec_idx
  );
endinterface
`default_nettype wire

// File: rtl/vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_sequencer
// Brief    : Replays stored vectors into a DUT and compacts its responses
//            into a 16-bit MISR signature.
// Revision : 1.0 - initial release
// ============================================================================
module vector_sequencer #(
  parameter int DEPTH = 128,
  parameter int IN_W  = 7,
  parameter int OUT_W = 7
) (
  input  wire logic         clk,
  input  wire logic         rst,
  vector_sequencer_if.slave bus
);
  localparam int          ADDR_W  = $clog2(DEPTH);
  localparam logic [7:0]  c_depth = 8'(DEPTH);
  localparam logic [1:0]  c_idle  = 2'd0;
  localparam logic [1:0]  c_run   = 2'd1;
  localparam logic [1:0]  c_drain = 2'd2;
  localparam logic [1:0]  c_done  = 2'd3;

  logic [IN_W:0]      r_mem [DEPTH];
  logic [1:0]         r_state;
  logic [7:0]         r_len;
  logic [7:0]         r_vec_idx;
  logic               r_cap;
  logic               r_dut_rst;
  logic [IN_W-1:0]    r_dut_in;
  logic [15:0]        r_sig;

  logic               w_active;
  logic               w_abort;
  logic               w_last;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [15:0]        w_sig_next;

  assign w_active   = (r_state == c_run) || (r_state == c_drain);
  assign w_abort    = bus.abort && w_active;
  assign w_last     = (r_vec_idx == r_len - 8'd1);
  assign w_rd_addr  = r_vec_idx[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_sig_next = {r_sig[14:0], r_sig[15] ^ r_sig[14] ^ r_sig[12] ^ r_sig[3]}
                      ^ {{(16-OUT_W){1'b0}}, bus.dut_out};

  // Writes are only accepted while no run is reading the memory.
  always_ff @(posedge clk) begin
    if (rst && bus.wr_en && !w_active)
      r_mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= c_idle;
      r_len     <= 8'd0;
      r_vec_idx <= 8'd0;
      r_cap     <= 1'b0;
      r_dut_rst <= 1'b1;
      r_dut_in  <= '0;
      r_sig     <= 16'hFFFF;
    end else begin
      r_cap <= 1'b0;
      // Response to vector k is captured one cycle after k is applied.
      if (r_cap && !w_abort)
        r_sig <= w_sig_next;
      case (r_state)
        c_idle: begin
          if (bus.start) begin
            r_sig     <= 16'hFFFF;
            r_len     <= (bus.len > c_depth) ? c_depth : bus.len;
            r_vec_idx <= 8'd0;
            if (bus.len == 8'd0) begin
              r_state <= c_done;
            end else begin
              r_state                <= c_run;
              {r_dut_rst, r_dut_in}  <= r_mem[{ADDR_W{1'b0}}];
            end
          end
        end
        c_run: begin
          if (w_abort || w_last) begin
            r_state   <= w_abort ? c_idle : c_drain;
            r_vec_idx <= 8'd0;
            r_dut_rst <= 1'b1;
            r_dut_in  <= '0;
            r_cap     <= !w_abort;
          end else begin
            r_cap                 <= 1'b1;
            r_vec_idx             <= r_vec_idx + 8'd1;
            {r_dut_rst, r_dut_in} <= r_mem[w_rd_addr];
          end
        end
        c_drain: r_state <= w_abort ? c_idle : c_done;
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.busy      = w_active;
  assign bus.done      = (r_state == c_done);
  assign bus.dut_rst   = r_dut_rst;
  assign bus.dut_in    = r_dut_in;
  assign bus.signature = r_sig;
  assign bus.vec_idx   = r_vec_idx;
endmodule
`default_nettype wire
